mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_iter_pkg.sv | 24 ++
 rtl/mdu_divstep.sv | 32 +++
 rtl/mdu_iter.sv | 176 +++++++++++++++++
 tb/tb_mdu_iter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the operation encodings, the FSM state type and a small
// helper that tells signed operations apart from unsigned ones.
package mdu_iter_pkg;

  localparam logic [2:0] MDU_OP_MULT  = 3'd0;
  localparam logic [2:0] MDU_OP_MULTU = 3'd1;
  localparam logic [2:0] MDU_OP_DIV   = 3'd2;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  function automatic logic f_is_signed(input logic [2:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step (purely combinational).
// Ports:
//   i_rem  partial remainder in (always < i_div for a non-zero divisor)
//   i_quo  dividend/quotient shift register in
//   i_div  divisor magnitude
//   o_rem  partial remainder out
//   o_quo  quotient shift register out, new quotient bit in LSB
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  always_comb begin
    w_shift = {i_rem, i_quo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, i_div});
    // When the subtraction is taken the result is below the divisor,
    // so the low WIDTH bits of the difference are exact.
    w_diff  = w_shift[WIDTH-1:0] - i_div;
    o_rem   = w_ge ? w_diff : w_shift[WIDTH-1:0];
    o_quo   = {i_quo[WIDTH-2:0], w_ge};
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO result registers.
// MULT/MULTU use a WIDTH-step shift-add multiplier, DIV/DIVU a
// WIDTH-step restoring divider; signed ops work on magnitudes and are
// sign-corrected in a final FIX cycle. MTHI/MTLO write HI/LO directly.
// Ports:
//   Clk_I, Rst_I     clock, synchronous active-high reset
//   Start_I, Op_I    request strobe and operation code
//   A_I, B_I         operands (A_I is also the MTHI/MTLO source)
//   Busy_O           iterative operation in progress
//   Done_O           one-cycle pulse when Hi_O/Lo_O are updated
//   Hi_O, Lo_O       HI/LO registers
//   DivZero_O        last divide had a zero divisor (sticky)
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk_I,
  input  logic             Rst_I,
  input  logic             Start_I,
  input  logic [2:0]       Op_I,
  input  logic [WIDTH-1:0] A_I,
  input  logic [WIDTH-1:0] B_I,
  output logic             Busy_O,
  output logic             Done_O,
  output logic [WIDTH-1:0] Hi_O,
  output logic [WIDTH-1:0] Lo_O,
  output logic             DivZero_O
);

  localparam int CW = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v,
                                             input logic en);
    return en ? -v : v;
  endfunction

  mdu_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div, r_sa, r_sb, r_dz;
  logic [WIDTH-1:0] r_m, r_acc_hi, r_acc_lo;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_done, r_divzero;

  logic             w_op_mul, w_op_div, w_sign_a, w_sign_b;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
  logic [WIDTH-1:0] w_div_rem, w_div_quo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo, w_rem;

  always_comb begin
    w_op_mul = (Op_I == MDU_OP_MULT) || (Op_I == MDU_OP_MULTU);
    w_op_div = (Op_I == MDU_OP_DIV)  || (Op_I == MDU_OP_DIVU);
    w_sign_a = f_is_signed(Op_I) & A_I[WIDTH-1];
    w_sign_b = f_is_signed(Op_I) & B_I[WIDTH-1];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (Start_I && w_op_mul)      w_state_nxt = ST_MUL;
        else if (Start_I && w_op_div) w_state_nxt = ST_DIV;
      end
      ST_MUL, ST_DIV: if (r_cnt == '0) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_I) begin
    if (Rst_I) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Multiply step: {acc_hi, acc_lo} holds partial product and the
  // not-yet-consumed multiplier bits; add multiplicand on LSB, shift right.
  always_comb begin
    w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_m} : '0);
    w_mul_hi  = w_mul_sum[WIDTH:1];
    w_mul_lo  = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
  end

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .i_rem (r_acc_hi),
    .i_quo (r_acc_lo),
    .i_div (r_m),
    .o_rem (w_div_rem),
    .o_quo (w_div_quo)
  );

  // Sign correction applied on the FIX edge. A zero divisor forces an
  // all-ones quotient; the remainder then already equals the dividend.
  always_comb begin
    w_prod = {r_acc_hi, r_acc_lo};
    if (r_sa ^ r_sb) w_prod = -w_prod;
    w_quo = r_dz ? '1 : f_neg(r_acc_lo, r_sa ^ r_sb);
    w_rem = f_neg(r_acc_hi, r_sa);
  end

  // Working datapath registers; they are always loaded before use.
  always_ff @(posedge Clk_I) begin
    case (r_state)
      ST_IDLE: begin
        if (Start_I && (w_op_mul || w_op_div)) begin
          r_is_div <= w_op_div;
          r_sa     <= w_sign_a;
          r_sb     <= w_sign_b;
          r_dz     <= w_op_div && (B_I == '0);
          r_cnt    <= CW'(WIDTH - 1);
          r_acc_hi <= '0;
          // Multiplicand/divisor goes in r_m, the shifted operand in acc_lo.
          r_m      <= w_op_mul ? f_neg(A_I, w_sign_a) : f_neg(B_I, w_sign_b);
          r_acc_lo <= w_op_mul ? f_neg(B_I, w_sign_b) : f_neg(A_I, w_sign_a);
        end
      end
      ST_MUL: begin
        r_acc_hi <= w_mul_hi;
        r_acc_lo <= w_mul_lo;
        r_cnt    <= r_cnt - 1'b1;
      end
      ST_DIV: begin
        r_acc_hi <= w_div_rem;
        r_acc_lo <= w_div_quo;
        r_cnt    <= r_cnt - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk_I) begin
    if (Rst_I) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start_I) begin
            if (Op_I == MDU_OP_MTHI) begin
              r_hi   <= A_I;
              r_done <= 1'b1;
            end else if (Op_I == MDU_OP_MTLO) begin
              r_lo   <= A_I;
              r_done <= 1'b1;
            end else if (w_op_div) begin
              r_divzero <= 1'b0;
            end
          end
        end
        ST_FIX: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            r_hi      <= w_rem;
            r_lo      <= w_quo;
            r_divzero <= r_dz;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy_O    = (r_state != ST_IDLE);
  assign Done_O    = r_done;
  assign Hi_O      = r_hi;
  assign Lo_O      = r_lo;
  assign DivZero_O = r_divzero;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter (WIDTH=32): directed vectors push
// expected HI/LO/flag and the cycle Done_O must appear in; a monitor
// pops and compares on every Done_O pulse.
module tb_mdu_iter;

  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2,
                         OP_DIVU = 3'd3, OP_MTHI = 3'd4, OP_MTLO = 3'd5;

  logic        Clk_I = 1'b0;
  logic        Rst_I, Start_I;
  logic [2:0]  Op_I;
  logic [31:0] A_I, B_I;
  logic        Busy_O, Done_O, DivZero_O;
  logic [31:0] Hi_O, Lo_O;

  mdu_iter #(.WIDTH(32)) dut (
    .Clk_I(Clk_I), .Rst_I(Rst_I), .Start_I(Start_I), .Op_I(Op_I),
    .A_I(A_I), .B_I(B_I), .Busy_O(Busy_O), .Done_O(Done_O),
    .Hi_O(Hi_O), .Lo_O(Lo_O), .DivZero_O(DivZero_O)
  );

  always #5 Clk_I = ~Clk_I;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   cyc = 0;

  always @(posedge Clk_I) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  always @(negedge Clk_I) begin
    if (Done_O === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done_at_cycle", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_hi"},   Hi_O, e.hi);
        chk({e.name, "_lo"},   Lo_O, e.lo);
        chk({e.name, "_dz"},   DivZero_O, e.dz);
        chk({e.name, "_cyc"},  64'(cyc), 64'(e.cyc));
        chk({e.name, "_busy"}, Busy_O, 1'b0);
      end
    end
  end

  // Must be called at the negedge on which start_op is called; lat is
  // the number of edges after the accepting edge until Done_O shows.
  task automatic expect_op(input logic [31:0] hi, input logic [31:0] lo,
                           input logic dz, input int lat, input string nm);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = dz; e.cyc = cyc + 1 + lat; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
    Start_I = 1'b1; Op_I = op; A_I = a; B_I = b;
    repeat (hold) @(negedge Clk_I);
    Start_I = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (Done_O !== 1'b1 && k < 100) begin
      @(negedge Clk_I);
      k++;
    end
    if (Done_O !== 1'b1) chk({nm, "_done_timeout"}, 64'(k), 64'd0);
  endtask

  initial begin
    Rst_I = 1'b1; Start_I = 1'b0; Op_I = '0; A_I = '0; B_I = '0;
    repeat (3) @(negedge Clk_I);
    chk("rst_busy", Busy_O, 1'b0);
    chk("rst_done", Done_O, 1'b0);
    chk("rst_hi", Hi_O, 32'h0);
    chk("rst_lo", Lo_O, 32'h0);
    chk("rst_dz", DivZero_O, 1'b0);
    Rst_I = 1'b0;
    @(negedge Clk_I);

    // MULT -3 * 5 = -15, Done after edge 33
    expect_op(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33, "mult_neg");
    start_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1);
    chk("mult_busy_after_accept", Busy_O, 1'b1);
    repeat (16) @(negedge Clk_I);
    chk("mult_busy_mid", Busy_O, 1'b1);
    chk("mult_lo_hold", Lo_O, 32'h0);
    wait_done("mult_neg");
    @(negedge Clk_I);

    expect_op(32'd2, 32'd14, 1'b0, 33, "divu_100_7");
    start_op(OP_DIVU, 32'd100, 32'd7, 1);
    wait_done("divu_100_7");

    // back-to-back: issued in the Done_O cycle
    expect_op(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, "div_m7_2");
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1);
    repeat (10) @(negedge Clk_I);
    chk("div_hi_hold", Hi_O, 32'd2);
    chk("div_lo_hold", Lo_O, 32'd14);
    wait_done("div_m7_2");

    expect_op(32'h0, 32'h8000_0000, 1'b0, 33, "div_ovf");
    start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_done("div_ovf");

    expect_op(32'd9, 32'hFFFF_FFFF, 1'b1, 33, "divu_zero");
    start_op(OP_DIVU, 32'd9, 32'd0, 1);
    wait_done("divu_zero");

    expect_op(32'd0, 32'd3, 1'b0, 33, "divu_9_3");
    start_op(OP_DIVU, 32'd9, 32'd3, 1);
    chk("divzero_cleared_on_accept", DivZero_O, 1'b0);
    wait_done("divu_9_3");
    @(negedge Clk_I);

    // Start_I held for 10 cycles: one operation only
    expect_op(32'd0, 32'd6, 1'b0, 33, "multu_hold");
    start_op(OP_MULTU, 32'd2, 32'd3, 10);
    wait_done("multu_hold");
    repeat (40) @(negedge Clk_I);

    // unused op code is ignored
    start_op(3'd6, 32'h5555_5555, 32'd1, 1);
    chk("unused_op_busy", Busy_O, 1'b0);
    chk("unused_op_lo", Lo_O, 32'd6);
    @(negedge Clk_I);

    // reset at edge 10 of a DIV aborts it
    start_op(OP_DIV, 32'd100, 32'd7, 1);
    repeat (9) @(negedge Clk_I);
    Rst_I = 1'b1;
    @(negedge Clk_I);
    Rst_I = 1'b0;
    chk("abort_busy", Busy_O, 1'b0);
    chk("abort_hi", Hi_O, 32'h0);
    chk("abort_lo", Lo_O, 32'h0);

    expect_op(32'h0, 32'h1234, 1'b0, 0, "mtlo");
    start_op(OP_MTLO, 32'h1234, 32'd0, 1);
    chk("mtlo_busy", Busy_O, 1'b0);
    wait_done("mtlo");

    expect_op(32'hABCD, 32'h1234, 1'b0, 0, "mthi");
    start_op(OP_MTHI, 32'hABCD, 32'd0, 1);
    wait_done("mthi");
    repeat (40) @(negedge Clk_I);

    // reset wins over a simultaneous start
    Rst_I = 1'b1;
    start_op(OP_MULT, 32'd3, 32'd3, 1);
    Rst_I = 1'b0;
    @(negedge Clk_I);
    chk("rst_prio_busy", Busy_O, 1'b0);
    chk("rst_prio_hi", Hi_O, 32'h0);
    repeat (40) @(negedge Clk_I);

    chk("done_pulse_count", 64'(n_done), 64'd9);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
